// File: rtl/bp_pkg.sv
// Shared branch-predictor types: 2-bit counter encoding and default history width.
package bp_pkg;

    localparam int HIS_W_DEF = 10;

    typedef logic [1:0] cnt2_t;

    localparam cnt2_t CNT_SNT = 2'b00;  // strongly not-taken
    localparam cnt2_t CNT_WNT = 2'b01;  // weakly not-taken
    localparam cnt2_t CNT_WT  = 2'b10;  // weakly taken
    localparam cnt2_t CNT_ST  = 2'b11;  // strongly taken

endpackage

// File: rtl/pat_his_tab_if.sv
// Lookup and training bus between the BHT/fetch side and the pattern history table.
interface pat_his_tab_if #(parameter int HIS_W = bp_pkg::HIS_W_DEF);

    logic             rd_en;
    logic [HIS_W-1:0] rd_his;
    logic             pred_valid;
    logic             pred_taken;
    logic [1:0]       pred_cnt;
    logic             upd_en;
    logic [HIS_W-1:0] upd_his;
    logic             upd_taken;
    logic             upd_mispred;
    logic [15:0]      mispred_cnt;

    modport master (
        output rd_en, rd_his, upd_en, upd_his, upd_taken,
        input  pred_valid, pred_taken, pred_cnt, upd_mispred, mispred_cnt
    );

    modport slave (
        input  rd_en, rd_his, upd_en, upd_his, upd_taken,
        output pred_valid, pred_taken, pred_cnt, upd_mispred, mispred_cnt
    );

endinterface

// File: rtl/pat_his_tab_sat_cnt2_nxt.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_cnt2_nxt
    import bp_pkg::*;
(
    input  cnt2_t cnt,
    input  logic  taken,
    output cnt2_t nxt
);

    // Step toward the resolved direction, holding at either end.
    always_comb begin
        nxt = cnt;
        if (taken && cnt != CNT_ST) begin
            nxt = cnt + 2'd1;
        end else if (!taken && cnt != CNT_SNT) begin
            nxt = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/pat_his_tab.sv
// Pattern history table: history-indexed 2-bit counters with registered
// prediction, training port and saturating mispredict counter.
module pat_his_tab
    import bp_pkg::*;
#(
    parameter int    HIS_W    = HIS_W_DEF,
    parameter cnt2_t INIT_CNT = CNT_WNT
) (
    input  logic clk,
    input  logic reset,
    pat_his_tab_if.slave bus
);

    localparam int N_ENT = 2 ** HIS_W;

    cnt2_t tab [N_ENT];
    cnt2_t upd_old;
    cnt2_t upd_nxt;
    cnt2_t rd_cnt;
    logic  upd_miss;

    assign upd_old  = tab[bus.upd_his];
    assign upd_miss = (upd_old[1] != bus.upd_taken);

    sat_cnt2_nxt u_nxt (
        .cnt   (upd_old),
        .taken (bus.upd_taken),
        .nxt   (upd_nxt)
    );

    // Lookup value, forwarding the post-update counter on a same-index collision.
    always_comb begin
        rd_cnt = tab[bus.rd_his];
        if (bus.upd_en && (bus.upd_his == bus.rd_his)) begin
            rd_cnt = upd_nxt;
        end
    end

    // Counter array: async clear to INIT_CNT, one training write per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_ENT; i++) begin
                tab[i] <= INIT_CNT;
            end
        end else if (bus.upd_en) begin
            tab[bus.upd_his] <= upd_nxt;
        end
    end

    // Registered prediction; value holds while no lookup is requested.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.pred_valid <= 1'b0;
            bus.pred_taken <= 1'b0;
            bus.pred_cnt   <= CNT_SNT;
        end else begin
            bus.pred_valid <= bus.rd_en;
            if (bus.rd_en) begin
                bus.pred_cnt   <= rd_cnt;
                bus.pred_taken <= rd_cnt[1];
            end
        end
    end

    // Mispredict flag and its saturating event count, updated together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.upd_mispred <= 1'b0;
            bus.mispred_cnt <= 16'h0000;
        end else begin
            bus.upd_mispred <= bus.upd_en && upd_miss;
            if (bus.upd_en && upd_miss && bus.mispred_cnt != 16'hFFFF) begin
                bus.mispred_cnt <= bus.mispred_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pat_his_tab.sv
// Randomized and directed bench for pat_his_tab against a counter-array model.
module tb_pat_his_tab;
    import bp_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    pat_his_tab_if #(.HIS_W(10)) bus ();

    pat_his_tab #(.HIS_W(10), .INIT_CNT(CNT_WNT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int model [1024];
    int e_vld, e_cnt, e_mis, e_mcnt;
    int n_cmp, n_err;
    int mcnt_base;
    logic [9:0] bht_his;
    logic       outcome;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) model[i] = 1;
        e_vld  = 0;
        e_cnt  = 0;
        e_mis  = 0;
        e_mcnt = 0;
    endtask

    task automatic drive_idle();
        bus.rd_en     = 1'b0;
        bus.rd_his    = '0;
        bus.upd_en    = 1'b0;
        bus.upd_his   = '0;
        bus.upd_taken = 1'b0;
    endtask

    // One clock of traffic: drive, advance the model, check all outputs after the edge.
    task automatic step(input logic re, input logic [9:0] rh,
                        input logic ue, input logic [9:0] uh, input logic ut);
        int old;
        bus.rd_en     = re;
        bus.rd_his    = rh;
        bus.upd_en    = ue;
        bus.upd_his   = uh;
        bus.upd_taken = ut;
        e_mis = 0;
        if (ue) begin
            old = model[uh];
            e_mis = ((old >= 2) != ut) ? 1 : 0;
            if (e_mis == 1 && e_mcnt < 65535) e_mcnt++;
            model[uh] = ut ? ((old < 3) ? old + 1 : 3) : ((old > 0) ? old - 1 : 0);
        end
        e_vld = re ? 1 : 0;
        if (re) e_cnt = model[rh];
        @(posedge clk);
        #1;
        check_val("pred_valid",  bus.pred_valid,  e_vld);
        check_val("pred_cnt",    bus.pred_cnt,    e_cnt);
        check_val("pred_taken",  bus.pred_taken,  e_cnt / 2);
        check_val("upd_mispred", bus.upd_mispred, e_mis);
        check_val("mispred_cnt", bus.mispred_cnt, e_mcnt);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();
        drive_idle();
        #3;
        check_val("rst_pred_valid",  bus.pred_valid,  0);
        check_val("rst_pred_cnt",    bus.pred_cnt,    0);
        check_val("rst_upd_mispred", bus.upd_mispred, 0);
        check_val("rst_mispred_cnt", bus.mispred_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // First lookup after reset sees INIT_CNT.
        step(1'b1, 10'h000, 1'b0, 10'h000, 1'b0);
        check_val("init_lookup", bus.pred_cnt, 1);

        // Saturate up at 0x155: only the update from WNT mispredicts.
        step(1'b0, 10'h000, 1'b1, 10'h155, 1'b1);
        check_val("up_mis0", bus.upd_mispred, 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 10'h000, 1'b1, 10'h155, 1'b1);
            check_val("up_mis_tail", bus.upd_mispred, 0);
        end
        step(1'b1, 10'h155, 1'b0, 10'h000, 1'b0);
        check_val("sat_up", bus.pred_cnt, 3);

        // Saturate down: mispredicts from ST and WT only.
        mcnt_base = int'(bus.mispred_cnt);
        for (int i = 0; i < 4; i++) step(1'b0, 10'h000, 1'b1, 10'h155, 1'b0);
        step(1'b1, 10'h155, 1'b0, 10'h000, 1'b0);
        check_val("sat_down", bus.pred_cnt, 0);
        check_val("down_mcnt", int'(bus.mispred_cnt) - mcnt_base, 2);

        // Same-index collision returns the post-update counter.
        step(1'b1, 10'h3FF, 1'b1, 10'h3FF, 1'b1);
        check_val("coll_cnt",   bus.pred_cnt,   2);
        check_val("coll_taken", bus.pred_taken, 1);

        // Lookup hold with rd_en low.
        step(1'b0, 10'h000, 1'b0, 10'h000, 1'b0);
        check_val("hold_cnt", bus.pred_cnt, 2);

        // Random mix over a small index pool to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            logic [9:0] rh, uh;
            rh = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 3));
            uh = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 3));
            step(1'($urandom), rh, 1'($urandom), uh, 1'($urandom));
        end

        // Reset mid-update clears everything at once and drops the update.
        step(1'b0, 10'h000, 1'b1, 10'h0AA, 1'b1);
        step(1'b0, 10'h000, 1'b1, 10'h0AA, 1'b1);
        step(1'b1, 10'h0AA, 1'b1, 10'h0AA, 1'b1);
        check_val("pre_rst_cnt", bus.pred_cnt, 3);
        bus.rd_en     = 1'b1;
        bus.rd_his    = 10'h0AA;
        bus.upd_en    = 1'b1;
        bus.upd_his   = 10'h0AA;
        bus.upd_taken = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_val("arst_pred_valid",  bus.pred_valid,  0);
        check_val("arst_pred_taken",  bus.pred_taken,  0);
        check_val("arst_pred_cnt",    bus.pred_cnt,    0);
        check_val("arst_upd_mispred", bus.upd_mispred, 0);
        check_val("arst_mispred_cnt", bus.mispred_cnt, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        step(1'b1, 10'h0AA, 1'b0, 10'h000, 1'b0);
        check_val("post_rst_cnt",  bus.pred_cnt,    1);
        check_val("post_rst_mcnt", bus.mispred_cnt, 0);

        // Alternating branch indexed by a bench-side BHT shift register.
        bht_his = 10'h000;
        outcome = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, bht_his, 1'b0, 10'h000, 1'b0);
            if (i >= 14) check_val("bht_pred", bus.pred_taken, outcome);
            step(1'b0, 10'h000, 1'b1, bht_his, outcome);
            if (i >= 14) check_val("bht_mis", bus.upd_mispred, 0);
            bht_his = {bht_his[8:0], outcome};
            outcome = ~outcome;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
